req_pending_encoder: RTL and testbench

- Request-capture stage that sits directly upstream of the 4-to-2 priority encoder.
- Detects rising edges on four request lines and records them in a pending register. Applies a mask, then presents the highest-priority pending request as a registered 2-bit code with a valid/ack handshake.
- The presented code stays frozen until the consumer acknowledges it, so downstream logic sees a stable index instead of a combinational encoding of live inputs.

---
 rtl/req_pending_encoder_if.sv | 22 ++
 rtl/req_pending_encoder.sv | 87 ++++++++
 tb/tb_req_pending_encoder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/req_pending_encoder_if.sv
// Request/mask/handshake bundle between a request source and req_pending_encoder.
// The slave modport is the encoder's view; master is the driver/consumer side.
interface req_pending_encoder_if;
    logic [3:0] req;
    logic [3:0] mask;
    logic       ack;
    logic       ovf_clr;
    logic       valid;
    logic [1:0] code;
    logic [3:0] pending;
    logic       overflow;

    modport master (
        output req, mask, ack, ovf_clr,
        input  valid, code, pending, overflow
    );

    modport slave (
        input  req, mask, ack, ovf_clr,
        output valid, code, pending, overflow
    );
endinterface

// File: rtl/req_pending_encoder.sv
// Captures rising edges on four request lines into a pending register and presents the
// highest-priority eligible one as a registered, ack-held 2-bit code.
module req_pending_encoder (
    input logic                  clk,
    input logic                  reset,
    req_pending_encoder_if.slave bus
);
    localparam logic StIdle    = 1'b0;
    localparam logic StPresent = 1'b1;

    logic [3:0] req_d;
    logic       armed_q;
    logic [3:0] pending_q, pending_d;
    logic       overflow_q, overflow_d;
    logic       state_q, state_d;
    logic [1:0] code_q, code_d;

    logic [3:0] rise;
    logic [3:0] clr;
    logic [3:0] eligible;
    logic [3:0] remaining;
    logic       take;

    function automatic logic [1:0] prio(input logic [3:0] v);
        logic [1:0] r;
        r = 2'b00;
        if (v[3])      r = 2'b11;
        else if (v[2]) r = 2'b10;
        else if (v[1]) r = 2'b01;
        return r;
    endfunction

    // The first clock after reset only loads req_d, so levels held through reset never count.
    assign rise = armed_q ? (bus.req & ~req_d) : 4'b0000;

    always_comb begin
        take       = (state_q == StPresent) && bus.ack;
        clr        = take ? (4'b0001 << code_q) : 4'b0000;
        pending_d  = rise | (pending_q & ~clr);
        overflow_d = (|(rise & pending_q & ~clr)) | (overflow_q & ~bus.ovf_clr);
        eligible   = pending_q & bus.mask;
        remaining  = eligible & ~clr;
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            StIdle: begin
                if (eligible != 4'b0000) begin
                    code_d  = prio(eligible);
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (take) begin
                    if (remaining != 4'b0000) code_d = prio(remaining);
                    else                      state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_d      <= 4'b0000;
            armed_q    <= 1'b0;
            pending_q  <= 4'b0000;
            overflow_q <= 1'b0;
            state_q    <= StIdle;
            code_q     <= 2'b00;
        end else begin
            req_d      <= bus.req;
            armed_q    <= 1'b1;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            code_q     <= code_d;
        end
    end

    assign bus.valid    = state_q;
    assign bus.code     = code_q;
    assign bus.pending  = pending_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_req_pending_encoder.sv
// Scoreboard bench for req_pending_encoder: a per-bit behavioural model predicts each
// presentation into a queue; a negedge monitor pops on every accepted code.
module tb_req_pending_encoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    req_pending_encoder_if bus ();

    req_pending_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    // Model state: per-bit flags; m_code = -1 means nothing presented.
    bit m_prev[4];
    bit m_pend[4];
    bit m_armed;
    bit m_ovf;
    int m_code;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int top_of(input bit v[4], input int skip);
        for (int i = 3; i >= 0; i--) if (v[i] && i != skip) return i;
        return -1;
    endfunction

    function automatic logic [3:0] packed_pend(input bit p[4]);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = p[i];
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_prev  <= '{0, 0, 0, 0};
            m_pend  <= '{0, 0, 0, 0};
            m_armed <= 1'b0;
            m_ovf   <= 1'b0;
            m_code  <= -1;
            exp_q.delete();
        end else begin : mdl
            automatic int taken = (m_code >= 0 && bus.ack) ? m_code : -1;
            automatic bit ov = m_ovf && !bus.ovf_clr;
            automatic bit elig[4];
            automatic bit np[4];
            automatic bit nprev[4];
            automatic int nxt;
            for (int i = 0; i < 4; i++) begin
                automatic bit rose = m_armed && bus.req[i] && !m_prev[i];
                elig[i]  = m_pend[i] && bus.mask[i];
                if (rose && m_pend[i] && i != taken) ov = 1'b1;
                np[i]    = rose || (m_pend[i] && i != taken);
                nprev[i] = bus.req[i];
            end
            if (m_code < 0)      nxt = top_of(elig, -1);
            else if (taken >= 0) nxt = top_of(elig, taken);
            else                 nxt = m_code;
            if (nxt >= 0 && (m_code < 0 || taken >= 0)) exp_q.push_back(nxt);
            m_code  <= nxt;
            m_ovf   <= ov;
            m_pend  <= np;
            m_prev  <= nprev;
            m_armed <= 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("valid", {31'b0, bus.valid}, {31'b0, m_code >= 0});
        chk("pending", {28'b0, bus.pending}, {28'b0, packed_pend(m_pend)});
        chk("overflow", {31'b0, bus.overflow}, {31'b0, m_ovf});
        if (bus.valid === 1'b1 && bus.ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL code_pop: got %0d expected none queued at %0t", bus.code, $time);
            end else begin
                automatic int e = exp_q.pop_front();
                chk("code", {30'b0, bus.code}, e);
            end
        end
    end

    task automatic drive(input logic [3:0] r, input logic [3:0] m, input logic a, input logic o);
        bus.req     = r;
        bus.mask    = m;
        bus.ack     = a;
        bus.ovf_clr = o;
        @(posedge clk);
        #2;
    endtask

    initial begin
        bus.req     = 4'b0000;
        bus.mask    = 4'hF;
        bus.ack     = 1'b0;
        bus.ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Single request, then ack.
        repeat (2) drive(4'b0000, 4'hF, 1'b0, 1'b0);
        drive(4'b0100, 4'hF, 1'b0, 1'b0);
        chk("single_pending", {28'b0, bus.pending}, 32'd4);
        drive(4'b0100, 4'hF, 1'b0, 1'b0);
        chk("single_code", {30'b0, bus.code}, 32'd2);
        drive(4'b0100, 4'hF, 1'b1, 1'b0);
        drive(4'b0000, 4'hF, 1'b0, 1'b0);

        // Simultaneous edges, back-to-back acks.
        drive(4'b1011, 4'hF, 1'b0, 1'b0);
        repeat (6) drive(4'b1011, 4'hF, bus.valid, 1'b0);
        drive(4'b0000, 4'hF, 1'b0, 1'b0);

        // Masked bit held, no pre-emption on unmask.
        repeat (2) drive(4'b1000, 4'b0111, 1'b0, 1'b0);
        repeat (2) drive(4'b1010, 4'b0111, 1'b0, 1'b0);
        repeat (2) drive(4'b1010, 4'hF, 1'b0, 1'b0);
        chk("no_preempt", {30'b0, bus.code}, 32'd1);
        drive(4'b1010, 4'hF, 1'b1, 1'b0);
        chk("after_unmask", {30'b0, bus.code}, 32'd3);
        repeat (3) drive(4'b1010, 4'hF, bus.valid, 1'b0);
        drive(4'b0000, 4'hF, 1'b0, 1'b0);

        // Overflow: re-edge before ack, re-edge on the ack cycle, then clear.
        drive(4'b0100, 4'hF, 1'b0, 1'b0);
        drive(4'b0000, 4'hF, 1'b0, 1'b0);
        drive(4'b0100, 4'hF, 1'b0, 1'b0);
        chk("overflow_set", {31'b0, bus.overflow}, 32'd1);
        drive(4'b0000, 4'hF, 1'b0, 1'b0);
        drive(4'b0100, 4'hF, 1'b1, 1'b0);
        chk("reedge_on_ack", {28'b0, bus.pending}, 32'd4);
        drive(4'b0100, 4'hF, 1'b1, 1'b1);
        chk("ovf_clr", {31'b0, bus.overflow}, 32'd0);
        repeat (2) drive(4'b0000, 4'hF, 1'b0, 1'b0);

        // Stray ack while nothing is presented.
        repeat (2) drive(4'b0001, 4'b0000, 1'b0, 1'b0);
        repeat (2) drive(4'b0001, 4'b0000, 1'b1, 1'b0);
        chk("stray_ack", {28'b0, bus.pending}, 32'd1);
        repeat (2) drive(4'b0001, 4'hF, 1'b0, 1'b0);
        drive(4'b0000, 4'hF, 1'b1, 1'b0);
        drive(4'b0000, 4'hF, 1'b0, 1'b0);

        // Asynchronous reset mid-handshake with requests held high.
        repeat (3) drive(4'b0110, 4'hF, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", {31'b0, bus.valid}, 32'd0);
        chk("rst_code", {30'b0, bus.code}, 32'd0);
        chk("rst_pending", {28'b0, bus.pending}, 32'd0);
        chk("rst_overflow", {31'b0, bus.overflow}, 32'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        repeat (4) drive(4'b0110, 4'hF, 1'b0, 1'b0);
        chk("held_no_edge", {31'b0, bus.valid}, 32'd0);
        drive(4'b0000, 4'hF, 1'b0, 1'b0);
        repeat (6) drive(4'b0110, 4'hF, bus.valid, 1'b0);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            automatic logic [3:0] r = bus.req;
            automatic logic [3:0] m = bus.mask;
            for (int b = 0; b < 4; b++) if ($urandom_range(3) == 0) r[b] = ~r[b];
            if (c % 16 == 0) m = ($urandom_range(2) == 0) ? 4'($urandom) : 4'hF;
            drive(r, m, 1'($urandom), ($urandom_range(7) == 0));
        end
        repeat (10) drive(4'b0000, 4'hF, 1'b1, 1'b0);
        drive(4'b0000, 4'hF, 1'b0, 1'b0);
        chk("queue_end", exp_q.size(), (m_code >= 0) ? 32'd1 : 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
